// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle unsigned subtractor computing a - b - bin,
// DIGIT bits per clock over K = WIDTH/DIGIT RUN cycles.
//
// Parameters:
//   WIDTH  operand/result width (>= 1)
//   DIGIT  bits processed per cycle; WIDTH must be a multiple of DIGIT
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, accepted only while ready=1 (IDLE or DONE)
//   a, b   minuend / subtrahend, latched on accepted start
//   bin    borrow-in, latched on accepted start
//   ready  high in IDLE and DONE
//   busy   high in RUN
//   done   one-cycle pulse in DONE; diff/bout hold the new result
//   diff   a - b - bin modulo 2^WIDTH, held until the next completion
//   bout   borrow-out, 1 when a < b + bin
//
// Build option:
//   SUB_SATURATE_EN  when defined, a final borrow of 1 clamps diff to zero
//                    (bout still reports the borrow).
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned K  = WIDTH / DIGIT;
    localparam int unsigned CW = $clog2(K + 1);
    localparam int unsigned DW = DIGIT + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic             brw_q;
    logic             bout_q;
    logic [CW-1:0]    cnt_q;

    logic                   accept_c;
    logic                   last_c;
    logic [DIGIT:0]         sub_c;
    logic [WIDTH+DIGIT-1:0] cat_c;
    logic [WIDTH-1:0]       res_next_c;

    // Start is honoured in IDLE and DONE only; RUN ignores it.
    assign accept_c = (state_q != S_RUN) && start;
    assign last_c   = (state_q == S_RUN) && (cnt_q == CW'(K - 1));

    // One digit of subtraction; the extra MSB is the outgoing borrow.
    assign sub_c = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - DW'(brw_q);

    // New digit enters the result register from the MSB side.
    assign cat_c      = {sub_c[DIGIT-1:0], res_q};
    assign res_next_c = cat_c[WIDTH+DIGIT-1:DIGIT];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_c) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status decode from the registered state
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_IDLE:  ready = 1'b1;
            S_RUN:   busy  = 1'b1;
            S_DONE:  begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ready = 1'b1;
        endcase
    end

    // Operand shifters, borrow flop, beat counter and held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (accept_c) begin
            a_q   <= a;
            b_q   <= b;
            brw_q <= bin;
            cnt_q <= '0;
        end else if (state_q == S_RUN) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            brw_q <= sub_c[DIGIT];
            res_q <= res_next_c;
            if (last_c) begin
`ifdef SUB_SATURATE_EN
                diff_q <= sub_c[DIGIT] ? '0 : res_next_c;
`else
                diff_q <= res_next_c;
`endif
                bout_q <= sub_c[DIGIT];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (8b/1-bit digits,
// 8b/4-bit digits, 1b/1-bit digit) checked every cycle against an
// arithmetic model, plus directed cases with literal expectations.
module tb_serial_subtractor;

`ifdef SUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start_in [3];
    logic [7:0] a_in     [3];
    logic [7:0] b_in     [3];
    logic       bin_in   [3];
    logic       rdy      [3];
    logic       bsy      [3];
    logic       dn       [3];
    logic       bo       [3];
    logic [7:0] df       [3];
    logic [7:0] df0;
    logic [7:0] df1;
    logic       df2;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(start_in[0]), .a(a_in[0]), .b(b_in[0]),
        .bin(bin_in[0]), .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .diff(df0), .bout(bo[0]));
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst_n(rst_n), .start(start_in[1]), .a(a_in[1]), .b(b_in[1]),
        .bin(bin_in[1]), .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .diff(df1), .bout(bo[1]));
    serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_w1d1 (
        .clk(clk), .rst_n(rst_n), .start(start_in[2]), .a(a_in[2][0:0]), .b(b_in[2][0:0]),
        .bin(bin_in[2]), .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .diff(df2), .bout(bo[2]));

    assign df[0] = df0;
    assign df[1] = df1;
    assign df[2] = {7'b0, df2};

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input int id, input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL dut%0d %s: got %0h expected %0h at %0t", id, nm, got, exp, $time);
    endtask

    function automatic int kk(input int i);
        return (i == 0) ? 8 : (i == 1) ? 2 : 1;
    endfunction

    function automatic int ww(input int i);
        return (i == 2) ? 1 : 8;
    endfunction

    // Reference result from plain integer arithmetic.
    task automatic expect_of(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                             output logic [7:0] d, output logic bout);
        int unsigned mask;
        int unsigned am;
        int unsigned bm;
        int          sd;
        mask = (32'd1 << w) - 1;
        am   = a & mask;
        bm   = b & mask;
        sd   = int'(am) - int'(bm) - int'(bin);
        bout = (am < bm + bin);
        d    = 8'(sd & int'(mask));
        if (SAT && bout) d = 8'h00;
    endtask

    // Model: job finishes K edges after acceptance; results appear with done.
    int         left   [3];
    logic       m_done [3];
    logic [7:0] m_diff [3];
    logic       m_bout [3];
    logic [7:0] p_diff [3];
    logic       p_bout [3];
    logic       acc;

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                left[i]   = 0;
                m_done[i] = 1'b0;
                m_diff[i] = 8'h00;
                m_bout[i] = 1'b0;
            end else begin
                acc       = (left[i] == 0) && start_in[i];
                m_done[i] = 1'b0;
                if (left[i] == 1) begin
                    m_diff[i] = p_diff[i];
                    m_bout[i] = p_bout[i];
                    m_done[i] = 1'b1;
                    left[i]   = 0;
                end else if (left[i] > 1) begin
                    left[i] = left[i] - 1;
                end
                if (acc) begin
                    left[i] = kk(i);
                    expect_of(ww(i), a_in[i], b_in[i], bin_in[i], p_diff[i], p_bout[i]);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk(i, "ready", 32'(rdy[i]), 32'(left[i] == 0));
                chk(i, "busy",  32'(bsy[i]), 32'(left[i] > 0));
                chk(i, "done",  32'(dn[i]),  32'(m_done[i]));
                chk(i, "diff",  32'(df[i]),  32'(m_diff[i]));
                chk(i, "bout",  32'(bo[i]),  32'(m_bout[i]));
            end
        end
    end

    // Directed transaction: called at negedge+1 with the instance ready.
    task automatic run(input int i, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input int lat, input int nbusy, input logic [7:0] ed, input logic eb);
        int n   = 0;
        int nb  = 0;
        bit got = 1'b0;
        start_in[i] = 1'b1;
        a_in[i]     = a;
        b_in[i]     = b;
        bin_in[i]   = bin;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bsy[i]) nb++;
            if (dn[i]) got = 1'b1;
            #1 start_in[i] = 1'b0;
        end
        chk(i, "latency", 32'(n), 32'(lat));
        chk(i, "busy_cycles", 32'(nb), 32'(nbusy));
        chk(i, "lit_diff", 32'(df[i]), 32'(ed));
        chk(i, "lit_bout", 32'(bo[i]), 32'(eb));
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int         nd;
        bit         seen;
        logic       ta, tb, tc, td, te;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_in[i] = 1'b0;
            a_in[i]     = 8'h00;
            b_in[i]     = 8'h00;
            bin_in[i]   = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk(i, "rst_ready", 32'(rdy[i]), 32'd1);
            chk(i, "rst_busy",  32'(bsy[i]), 32'd0);
            chk(i, "rst_done",  32'(dn[i]),  32'd0);
            chk(i, "rst_diff",  32'(df[i]),  32'd0);
            chk(i, "rst_bout",  32'(bo[i]),  32'd0);
        end
        chk_en = 1'b1;
        #1 rst_n = 1'b1;
        tick();

        run(0, 8'h05, 8'h03, 1'b0, 9, 8, 8'h02, 1'b0);
        run(0, 8'h00, 8'h01, 1'b0, 9, 8, SAT ? 8'h00 : 8'hFF, 1'b1);
        run(1, 8'h80, 8'h80, 1'b1, 3, 2, SAT ? 8'h00 : 8'hFF, 1'b1);

        for (int v = 0; v < 8; v++) begin
            ta = v[2];
            tb = v[1];
            tc = v[0];
            td = ta ^ tb ^ tc;
            te = (~ta & tb) | (~(ta ^ tb) & tc);
            if (SAT && te) td = 1'b0;
            run(2, {7'b0, ta}, {7'b0, tb}, tc, 2, 1, {7'b0, td}, te);
        end

        // Start during RUN is ignored; only one done for the first job
        tick();
        start_in[0] = 1'b1; a_in[0] = 8'h20; b_in[0] = 8'h01; bin_in[0] = 1'b0;
        tick();
        start_in[0] = 1'b0;
        tick();
        start_in[0] = 1'b1; a_in[0] = 8'h10;
        tick();
        start_in[0] = 1'b0; a_in[0] = 8'h00;
        nd = 0;
        seen = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (dn[0]) begin
                nd++;
                if (!seen) chk(0, "ignore_diff", 32'(df[0]), 32'h1F);
                seen = 1'b1;
            end
            #1;
        end
        chk(0, "ignore_done_count", 32'(nd), 32'd1);

        // Reset mid-RUN aborts with no done pulse
        start_in[0] = 1'b1; a_in[0] = 8'h55; b_in[0] = 8'h11;
        tick();
        start_in[0] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk(0, "abort_ready", 32'(rdy[0]), 32'd1);
        chk(0, "abort_busy",  32'(bsy[0]), 32'd0);
        chk(0, "abort_diff",  32'(df[0]),  32'd0);
        chk(0, "abort_bout",  32'(bo[0]),  32'd0);
        #1 rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dn[0]) nd++;
            #1;
        end
        chk(0, "abort_no_done", 32'(nd), 32'd0);
        run(0, 8'h09, 8'h04, 1'b0, 9, 8, 8'h05, 1'b0);

        // Random traffic including back-to-back starts in DONE
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                start_in[i] = ($urandom_range(0, 3) != 0);
                a_in[i]     = 8'($urandom);
                b_in[i]     = 8'($urandom);
                bin_in[i]   = 1'($urandom);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) start_in[i] = 1'b0;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>=1).
REQ-002 SHALL have parameter DIGIT, default 1, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only when ready=1.
REQ-006 SHALL have port a  input  WIDTH  minuend, latched on accepted start.
REQ-007 SHALL have port b  input  WIDTH  subtrahend, latched on accepted start.
REQ-008 SHALL have port bin  input  1  borrow-in, latched on accepted start.
REQ-009 SHALL have port ready  output  1  high in IDLE and DONE; start accepted.
REQ-010 SHALL have port busy  output  1  high in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port diff  output  WIDTH  result, a - b - bin modulo 2^WIDTH.
REQ-013 SHALL have port bout  output  1  borrow-out; 1 when a < b + bin (unsigned).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; transitions: IDLE->RUN on start; RUN->DONE after K=WIDTH/DIGIT RUN cycles; DONE->RUN on start, else DONE->IDLE.
REQ-015 SHALL on accepted start capture a, b, bin into internal shift registers and borrow flop and clear the beat counter.
REQ-016 SHALL in each RUN cycle subtract the DIGIT LSBs of the a/b shift registers and the borrow flop, shift the DIGIT-bit difference into the result register from the MSB side, and update the borrow flop.
REQ-017 SHALL use a beat counter of width ceil(log2(K+1)); RUN exits when count reaches K-1 at a clock edge; no wrap-around beyond K.
REQ-018 SHALL assert done exactly during the single DONE cycle, K+1 cycles after the edge that accepted start.
REQ-019 SHALL update diff and bout only at RUN->DONE transition; hold them unchanged otherwise, including through IDLE and subsequent RUN.
REQ-020 SHALL ignore start while busy=1; operands in flight are not disturbed.
REQ-021 SHALL accept start in DONE cycle (back-to-back); done pulses for old result while new operands latch.
REQ-022 SHALL produce results equal to WIDTH-bit ripple subtraction of latched operands for all DIGIT values.
REQ-023 SHALL for WIDTH=1, DIGIT=1 reproduce the full-subtractor truth table: diff=a^b^bin, bout=(~a&b)|(~(a^b)&bin).

Reset
REQ-024 SHALL on rst_n=0 immediately force state IDLE, ready=1, busy=0, done=0, diff=0, bout=0, counter=0, internal registers=0, independent of clk.
REQ-025 SHALL abort any RUN on reset with no done pulse; first accepted start after rst_n deasserts behaves as from power-up.

Configuration
REQ-026 SHALL support macro SUB_SATURATE_EN: when defined, a final borrow of 1 forces diff to all zeros (bout still 1); when undefined, diff is the modulo-2^WIDTH result.

Verification
REQ-027 SHALL cover WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0 -> done 9 cycles after start, diff=0x02, bout=0.
REQ-028 SHALL cover WIDTH=8, DIGIT=1: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1 without SUB_SATURATE_EN; diff=0x00, bout=1 with it.
REQ-029 SHALL cover WIDTH=8, DIGIT=4: a=0x80, b=0x80, bin=1 -> busy 2 cycles, done 3 cycles after start, diff=0xFF, bout=1.
REQ-030 SHALL cover start pulsed with a=0x10 during RUN of a=0x20, b=0x01 -> second start ignored, diff=0x1F, single done.
REQ-031 SHALL cover rst_n low for one cycle mid-RUN -> ready=1, diff=0, bout=0, no done; next start a=0x09, b=0x04 -> diff=0x05.
REQ-032 SHALL cover WIDTH=1, DIGIT=1: all 8 (a,b,bin) combinations -> diff/bout match REQ-023 truth table.
